// File: rtl/arena_access_arbiter_pkg.sv
// Shared definitions for the arena map access arbiter: colours, widths,
// FSM state encoding and player identifiers.
package arena_access_arbiter_pkg;

    // Map geometry: 128x128 cells addressed as {y, x}
    localparam int ARENA_COORD_W = 7;
    localparam int ARENA_ADDR_W  = 2 * ARENA_COORD_W;
    localparam int ARENA_DATA_W  = 2;

    // Cell colours
    localparam logic [1:0] COL_BLACK = 2'b00;
    localparam logic [1:0] COL_RED   = 2'b01;
    localparam logic [1:0] COL_BLUE  = 2'b10;

    // FSM state encoding; CLEAR is zero so the debug view reads 0 in reset
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_CLEAR = 3'd0,
        ST_READY = 3'd1,
        ST_RD    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WR    = 3'd4
    } arb_state_t;

    // Requester identity
    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_t;

endpackage

// File: rtl/arena_access_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker. A lone requester always wins; when both
// request, the pointer decides and then moves to the loser so that the next
// contended grant goes the other way.
module arena_access_arbiter_rr_arbiter2
    import arena_access_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    req1,
    input  logic    req2,
    input  logic    grant_en,
    output logic    gnt_valid,
    output player_t gnt_id
);

    player_t rr_ptr_q;

    // Pick a winner among the current requesters
    always_comb begin
        gnt_valid = req1 | req2;
        gnt_id    = PLAYER_1;
        if (req1 && req2) begin
            gnt_id = rr_ptr_q;
        end else if (req2) begin
            gnt_id = PLAYER_2;
        end
    end

    // Pointer flips only after a contended grant is actually taken
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= PLAYER_1;
        end else if (grant_en && req1 && req2) begin
            rr_ptr_q <= (rr_ptr_q == PLAYER_1) ? PLAYER_2 : PLAYER_1;
        end
    end

endmodule

// File: rtl/arena_access_arbiter.sv
// Arena map RAM access arbiter. Owns the single RAM port, sweeps the map to
// BLACK after reset and on every game_init, and serves the two players with
// atomic check-and-stamp accesses (read cell, report prior colour, write the
// player colour only when the cell was BLACK).
//
// Handshake: reqN is a level held by the requester, with xN/yN stable, until
// it sees ackN. ackN is a single-cycle pulse and hitN is valid with it and
// holds until the next ackN. A requester is not considered for a new grant
// in the cycle its ack is high, so a held request is not double-served.
module arena_access_arbiter
    import arena_access_arbiter_pkg::*;
#(
    parameter int                COORD_W      = ARENA_COORD_W,
    parameter int                DATA_W       = ARENA_DATA_W,
    parameter logic [DATA_W-1:0] P1_COLOUR    = DATA_W'(COL_RED),
    parameter logic [DATA_W-1:0] P2_COLOUR    = DATA_W'(COL_BLUE),
    parameter bit                CLEAR_ON_RST = 1'b1,
    localparam int               ADDR_W       = 2 * COORD_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               game_init,
    input  logic               req1,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               ack1,
    output logic [DATA_W-1:0]  hit1,
    input  logic               req2,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    output logic               ack2,
    output logic [DATA_W-1:0]  hit2,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [DATA_W-1:0]  ram_din,
    input  logic [DATA_W-1:0]  ram_dout,
    output logic               busy,
    output logic               clear_done,
    output logic [STATE_W-1:0] dbg_state
);

    localparam logic [DATA_W-1:0] BLACK = DATA_W'(COL_BLACK);

    arb_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic                armed_q;       // low only in the first cycle after reset
    player_t             acc_id_q;
    logic [ADDR_W-1:0]   acc_addr_q;
    logic [DATA_W-1:0]   acc_colour_q;
    logic                ack1_q, ack2_q;
    logic [DATA_W-1:0]   hit1_q, hit2_q;
    logic                clear_done_q;

    logic                elig1, elig2;
    logic                grant_en;
    logic                gnt_valid;
    player_t             gnt_id;
    logic                granted;
    logic                clear_wr;
    logic                last_addr;
    logic                stamp_wr;

    arena_access_arbiter_rr_arbiter2 u_rr (
        .clk       (clk),
        .reset_n   (reset_n),
        .req1      (elig1),
        .req2      (elig2),
        .grant_en  (grant_en),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Eligibility, grant strobe and write qualifiers
    always_comb begin
        elig1     = req1 & ~ack1_q;
        elig2     = req2 & ~ack2_q;
        grant_en  = (state_q == ST_READY) && !game_init;
        granted   = grant_en && gnt_valid;
        clear_wr  = (state_q == ST_CLEAR) && armed_q;
        last_addr = (clr_cnt_q == {ADDR_W{1'b1}});
        // An aborted access must not leave a stamp behind
        stamp_wr  = (state_q == ST_WR) && (ram_dout == BLACK) && !game_init;
    end

    // Next-state logic; game_init overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clear_wr && last_addr) state_d = ST_READY;
            ST_READY: if (granted) state_d = ST_RD;
            ST_RD:    state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_WR;
            ST_WR:    state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
        if (game_init) begin
            state_d = ST_CLEAR;
        end
    end

    // RAM port mux: clear sweep versus latched player access
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = BLACK;
        case (state_q)
            ST_CLEAR: begin
                ram_addr = clr_cnt_q;
                ram_we   = armed_q;
            end
            ST_RD, ST_WAIT: begin
                ram_addr = acc_addr_q;
            end
            ST_WR: begin
                ram_addr = acc_addr_q;
                ram_we   = stamp_wr;
                ram_din  = stamp_wr ? acc_colour_q : BLACK;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    // State, sweep counter, latched access and ack/hit registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
            clr_cnt_q    <= '0;
            armed_q      <= 1'b0;
            acc_id_q     <= PLAYER_1;
            acc_addr_q   <= '0;
            acc_colour_q <= '0;
            ack1_q       <= 1'b0;
            ack2_q       <= 1'b0;
            hit1_q       <= '0;
            hit2_q       <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= 1'b1;
            clear_done_q <= clear_wr && last_addr && !game_init;
            ack1_q       <= 1'b0;
            ack2_q       <= 1'b0;

            if (game_init) begin
                clr_cnt_q <= '0;
            end else if (clear_wr) begin
                clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
            end

            if (granted) begin
                acc_id_q <= gnt_id;
                if (gnt_id == PLAYER_2) begin
                    acc_addr_q   <= {y2, x2};
                    acc_colour_q <= P2_COLOUR;
                end else begin
                    acc_addr_q   <= {y1, x1};
                    acc_colour_q <= P1_COLOUR;
                end
            end

            if ((state_q == ST_WR) && !game_init) begin
                if (acc_id_q == PLAYER_2) begin
                    ack2_q <= 1'b1;
                    hit2_q <= ram_dout;
                end else begin
                    ack1_q <= 1'b1;
                    hit1_q <= ram_dout;
                end
            end
        end
    end

    assign ack1       = ack1_q;
    assign ack2       = ack2_q;
    assign hit1       = hit1_q;
    assign hit2       = hit2_q;
    assign clear_done = clear_done_q;
    assign busy       = armed_q && (state_q != ST_READY);
    assign dbg_state  = state_q;

endmodule
